sample_ring_reader: RTL and testbench

//  Read-side sample buffer for the 12-bit sample path. The producer pushes one sample per wr_en

---
 rtl/sample_pkg.sv | 10 +
 rtl/sample_ring_reader_if.sv | 13 +
 rtl/sample_ring_mem.sv | 22 ++
 rtl/sample_ring_reader.sv | 104 ++++++++++
 tb/tb_sample_ring_reader.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sample_pkg.sv
// Shared types and widths for the 12-bit sample read-side buffer.
package sample_pkg;
  localparam int SAMPLE_W   = 12;
  localparam int DROP_CNT_W = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;
endpackage

// File: rtl/sample_ring_reader_if.sv
// Sample push strobe and valid/ready drain handshake of the sample ring reader.
interface sample_ring_reader_if;
  import sample_pkg::*;

  logic                wr_en;
  logic [SAMPLE_W-1:0] wr_data;
  logic                rd_ready;
  logic                rd_valid;
  logic [SAMPLE_W-1:0] rd_data;

  modport master (output wr_en, wr_data, rd_ready, input rd_valid, rd_data);
  modport slave  (input wr_en, wr_data, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/sample_ring_mem.sv
// Ring storage: synchronous write port, asynchronous read port.
module sample_ring_mem
  import sample_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [SAMPLE_W-1:0] rdata
);
  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sample_ring_reader.sv
// Read-side sample ring with a registered valid/ready output stage.
// Optional drop statistics counter built when SAMPLE_RING_DROP_STATS_EN is defined.
//
// state     | meaning
// OUT_EMPTY | output register holds no sample, rd_valid=0
// OUT_FULL  | output register holds a sample, rd_valid=1
module sample_ring_reader
  import sample_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sample_ring_reader_if.slave   bus,
  input  logic                  clr_ovf,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  out_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [SAMPLE_W-1:0] ring_rdata, rd_data_q;
  logic                push, drop, ring_pop, rd_valid_c;

  // Fullness is judged on the registered count, so a pop in the same cycle cannot rescue a push.
  assign push = bus.wr_en && (count != FULL_CNT);
  assign drop = bus.wr_en && (count == FULL_CNT);

  sample_ring_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (ring_rdata)
  );

  always_comb begin
    state_d    = state_q;
    ring_pop   = 1'b0;
    rd_valid_c = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (count != '0) begin
          ring_pop = 1'b1;
          state_d  = OUT_FULL;
        end
      end
      OUT_FULL: begin
        rd_valid_c = 1'b1;
        if (bus.rd_ready) begin
          if (count != '0) ring_pop = 1'b1;
          else             state_d  = OUT_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= OUT_EMPTY;
      rd_data_q <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ring_pop) begin
        rd_data_q <= ring_rdata;
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, ring_pop};
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign bus.rd_valid = rd_valid_c;
  assign bus.rd_data  = rd_data_q;

`ifdef SAMPLE_RING_DROP_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // A drop wins over a simultaneous clear, matching the overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end else if (clr_ovf) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_sample_ring_reader.sv
// Directed scoreboard bench for sample_ring_reader.
module tb_sample_ring_reader;
  import sample_pkg::*;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
`ifdef SAMPLE_RING_DROP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_ovf = 1'b0;
  logic [ADDR_W:0] count;
  logic overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  sample_ring_reader_if bus ();

  sample_ring_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [SAMPLE_W-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [SAMPLE_W-1:0] d, input bit kept);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (kept) sb.push_back(d);
  endtask

  // A handshake seen between edges completes at the next rising edge.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
      if (sb.size() == 0) check("unexpected_output", {20'h0, bus.rd_data}, 32'hFFFF_FFFF);
      else                check("rd_data_order", {20'h0, bus.rd_data}, {20'h0, sb.pop_front()});
    end
  end

  initial begin
    int max_cnt;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    #12;
    check("reset_rd_valid", {31'h0, bus.rd_valid}, 32'd0);
    check("reset_rd_data", {20'h0, bus.rd_data}, 32'd0);
    check("reset_count", {27'h0, count}, 32'd0);
    check("reset_overflow", {31'h0, overflow}, 32'd0);
    check("reset_drop_cnt", {16'h0, drop_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: single push
    bus.rd_ready = 1'b1;
    push_sample(12'hA5C, 1);
    tick();
    bus.wr_en = 1'b0;
    check("t1_count_after_push", {27'h0, count}, 32'd1);
    check("t1_not_valid_yet", {31'h0, bus.rd_valid}, 32'd0);
    tick();
    check("t1_valid", {31'h0, bus.rd_valid}, 32'd1);
    check("t1_data", {20'h0, bus.rd_data}, 32'hA5C);
    check("t1_count_zero", {27'h0, count}, 32'd0);
    tick();
    check("t1_valid_drop", {31'h0, bus.rd_valid}, 32'd0);

    // 2: continuous stream across pointer wrap
    max_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      push_sample(12'(i + 12'h100), 1);
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    bus.wr_en = 1'b0;
    check("t2_max_count", max_cnt, 32'd1);
    repeat (3) tick();
    check("t2_drained", sb.size(), 32'd0);
    check("t2_overflow", {31'h0, overflow}, 32'd0);

    // 3: overflow with consumer stalled
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_sample(12'(i), i < DEPTH + 1);
      tick();
    end
    bus.wr_en = 1'b0;
    check("t3_count_full", {27'h0, count}, DEPTH);
    check("t3_overflow", {31'h0, overflow}, 32'd1);
    check("t3_drop_cnt", {16'h0, drop_cnt}, STATS ? 32'd3 : 32'd0);
    check("t3_head_data", {20'h0, bus.rd_data}, 32'd0);
    check("t3_head_valid", {31'h0, bus.rd_valid}, 32'd1);

    // 5: clear racing a drop, then clear alone
    clr_ovf = 1'b1;
    push_sample(12'hEEE, 0);
    tick();
    bus.wr_en = 1'b0;
    check("t5_set_beats_clr", {31'h0, overflow}, 32'd1);
    check("t5_drop_cnt_race", {16'h0, drop_cnt}, STATS ? 32'd4 : 32'd0);
    tick();
    clr_ovf = 1'b0;
    check("t5_clr_overflow", {31'h0, overflow}, 32'd0);
    check("t5_clr_drop_cnt", {16'h0, drop_cnt}, 32'd0);

    bus.rd_ready = 1'b1;
    repeat (20) tick();
    check("t3_drain_all", sb.size(), 32'd0);
    check("t3_count_empty", {27'h0, count}, 32'd0);

    // 4: stall then single accept
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_sample(12'hB00 + 12'(i), 1);
      tick();
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stall_data", {20'h0, bus.rd_data}, 32'hB00);
    end
    check("t4_stall_count", {27'h0, count}, 32'd2);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("t4_one_consumed", {27'h0, count}, 32'd1);
    check("t4_next_data", {20'h0, bus.rd_data}, 32'hB01);
    tick();
    check("t4_still_next", {20'h0, bus.rd_data}, 32'hB01);
    bus.rd_ready = 1'b1;
    repeat (4) tick();
    check("t4_drained", sb.size(), 32'd0);

    // 6: async reset mid-operation
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_sample(12'hC00 + 12'(i), i < DEPTH + 1);
      tick();
    end
    bus.wr_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'h0, bus.rd_valid}, 32'd0);
    check("t6_rst_count", {27'h0, count}, 32'd0);
    check("t6_rst_overflow", {31'h0, overflow}, 32'd0);
    sb.delete();
    tick();
    #2 reset = 1'b1;
    @(posedge clk); #1;
    bus.rd_ready = 1'b1;
    push_sample(12'hD00, 1);
    tick();
    push_sample(12'hD01, 1);
    tick();
    bus.wr_en = 1'b0;
    check("t6_first_after_rst", {20'h0, bus.rd_data}, 32'hD00);
    check("t6_valid_after_rst", {31'h0, bus.rd_valid}, 32'd1);
    repeat (4) tick();
    check("t6_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
